mem_seq_master: RTL
===================

MEM_SEQ_MASTER -- requirements
Module: mem_seq_master

Interface
REQ-001 SHALL provide parameter ADDR_W, default 11, meaning the width of the memory-channel byte address.
REQ-002 SHALL provide parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for M_DataRdy.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command request.
REQ-006 SHALL have port cmd_ready, output, 1 bit: command accepted when both are high at an edge.
REQ-007 SHALL have port cmd_write, input, 1 bit: 1 = write burst, 0 = read burst.
REQ-008 SHALL have port cmd_addr, input, ADDR_W bits: start byte address.
REQ-009 SHALL have port cmd_len, input, 8 bits: byte count, 0 allowed.
REQ-010 SHALL have ports wr_valid (input, 1), wr_ready (output, 1) and wr_data (input, 8): the write-data stream.
REQ-011 SHALL have ports rd_valid (output, 1), rd_ready (input, 1) and rd_data (output, 8): the read-data stream.
REQ-012 SHALL have port done, output, 1 bit: one-cycle burst-complete pulse.
REQ-013 SHALL have port error, output, 1 bit: sticky timeout flag.
REQ-014 SHALL have the memory-channel outputs Mout_oe_ram (1), Mout_we_ram (1), Mout_addr_ram (ADDR_W), Mout_Wdata_ram (8) and Mout_data_ram_size (4).
REQ-015 SHALL have the memory-channel inputs M_Rdata_ram (8) and M_DataRdy (1).

Function
REQ-016 SHALL implement FSM states IDLE, REQ, GAP, DONE; cmd_ready=1 only in IDLE.
REQ-017 On command acceptance, SHALL latch addr, len and direction; if len=0 go to DONE, else go to REQ.
REQ-018 In REQ (read), SHALL assert Mout_oe_ram only when the read buffer has a free entry, and hold oe, addr and size stable until M_DataRdy=1 is sampled.
REQ-019 In REQ (write), SHALL assert wr_ready and drive Mout_we_ram=wr_valid with Mout_Wdata_ram=wr_data; a word transfers on wr_valid&wr_ready; the access completes when M_DataRdy=1 is sampled with we high.
REQ-020 SHALL capture M_Rdata_ram into the read buffer on the edge where oe=1 and M_DataRdy=1.
REQ-021 After each completed access, SHALL enter GAP for exactly one cycle with oe=we=0, increment the address modulo 2^ADDR_W (wrap 2^ADDR_W-1 -> 0) and decrement the remaining count; then go to REQ if count>0, else DONE.
REQ-022 In DONE, SHALL pulse done=1 for one cycle and return to IDLE; for reads, done SHALL NOT wait for read-buffer drain.
REQ-023 SHALL never assert Mout_oe_ram and Mout_we_ram in the same cycle.
REQ-024 Mout_data_ram_size SHALL be constant 8 (byte access); oe and we SHALL be 0 outside REQ.
REQ-025 The read buffer SHALL be a 2-entry FIFO; rd_valid=not-empty; pop on rd_valid&rd_ready; a simultaneous push and pop when full SHALL be legal.
REQ-026 A read byte cost (rd_ready=1, responder read latency 2) SHALL be 3 cycles; a write byte cost (latency 1, wr_valid=1) SHALL be 2 cycles.
REQ-027 A new command SHALL clear error on acceptance.

Reset
REQ-028 When reset=1 at an edge, SHALL force state IDLE, cmd_ready=1, oe=we=0, addr=0, wr_ready=0, rd_valid=0 (buffer flushed), done=0, error=0, and the timeout counter to 0.
REQ-029 Reset mid-burst SHALL abort the burst without producing a done pulse; strobes SHALL be low from the following cycle.

Configuration
REQ-030 With macro MEM_SEQ_MASTER_TIMEOUT_EN defined, SHALL count the REQ cycles in which oe or we is high and M_DataRdy=0.
REQ-031 With MEM_SEQ_MASTER_TIMEOUT_EN defined, reaching TIMEOUT SHALL set error=1, drop strobes, discard remaining bytes and go to DONE.
REQ-032 Without MEM_SEQ_MASTER_TIMEOUT_EN, error SHALL be tied 0, no counter logic SHALL exist, and the block SHALL wait indefinitely.

Verification
REQ-033 Read addr=0x010, len=3, memory 0xA1,0xB2,0xC3, read latency 2, rd_ready=1 -> rd_data A1,B2,C3 in order; oe addresses 0x010..0x012; done 9-10 cycles after acceptance.
REQ-034 Write addr=0x7FE, len=4, data 11,22,33,44, write latency 1 -> writes to 0x7FE, 0x7FF, 0x000, 0x001 (wrap); done once.
REQ-035 Read len=5 with rd_ready=0 -> exactly 2 bytes fetched, oe low while full; raising rd_ready resumes and all 5 bytes arrive in order.
REQ-036 cmd_len=0 -> no oe/we activity; done pulses one cycle after acceptance.
REQ-037 With TIMEOUT_EN, TIMEOUT=255 and M_DataRdy stuck 0 -> error=1 after 255 wait cycles, done pulses, and the next command clears error.
REQ-038 Reset asserted in the middle of a 4-byte write -> strobes low the next cycle, no done pulse, cmd_ready=1 after reset.

Source files
------------

// File: rtl/mem_seq_master.sv
// Byte-burst memory-channel master: streams len bytes to/from sequential addresses, one access per REQ/GAP pair.
// Optional stall watchdog is compiled in when MEM_SEQ_MASTER_TIMEOUT_EN is defined.
module mem_seq_master #(
  parameter int ADDR_W  = 11,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [7:0]        rd_data,
  output logic              done,
  output logic              error,
  output logic              Mout_oe_ram,
  output logic              Mout_we_ram,
  output logic [ADDR_W-1:0] Mout_addr_ram,
  output logic [7:0]        Mout_Wdata_ram,
  output logic [3:0]        Mout_data_ram_size,
  input  logic [7:0]        M_Rdata_ram,
  input  logic              M_DataRdy
);

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        count_q;
  logic              write_q;

  logic [7:0]        fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_cnt;

  logic              fifo_full;
  logic              accept;
  logic              strobe;
  logic              access_done;
  logic              push;
  logic              pop;
  logic              timeout_hit;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mem_seq_master: TIMEOUT must be at least 1");
  end

  // A read strobe is only raised with a free buffer slot, so once raised it
  // stays up until the responder answers (pops can only free more space).
  assign fifo_full   = (fifo_cnt == 2'd2);
  assign accept      = (state == IDLE) && cmd_valid;
  assign strobe      = (state == REQ) && (write_q ? wr_valid : !fifo_full);
  assign access_done = strobe && M_DataRdy;
  assign push        = access_done && !write_q;
  assign pop         = rd_valid && rd_ready;

  assign rd_valid           = (fifo_cnt != 2'd0);
  assign rd_data            = fifo_mem[rd_ptr];
  assign Mout_addr_ram      = addr_q;
  assign Mout_data_ram_size = 4'd8;

  always_comb begin
    state_next     = state;
    cmd_ready      = 1'b0;
    wr_ready       = 1'b0;
    Mout_oe_ram    = 1'b0;
    Mout_we_ram    = 1'b0;
    Mout_Wdata_ram = 8'h00;
    done           = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = (cmd_len == 8'd0) ? DONE : REQ;
      end
      REQ: begin
        Mout_oe_ram = strobe && !write_q;
        Mout_we_ram = strobe && write_q;
        wr_ready    = write_q;
        if (write_q) Mout_Wdata_ram = wr_data;
        if (access_done)      state_next = GAP;
        else if (timeout_hit) state_next = DONE;
      end
      GAP:     state_next = (count_q == 8'd0) ? DONE : REQ;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Address and remaining count advance on the completing edge, so GAP
  // already sees the post-access values when deciding REQ vs DONE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      count_q <= 8'd0;
      write_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= cmd_addr;
        count_q <= cmd_len;
        write_q <= cmd_write;
      end else if (access_done) begin
        addr_q  <= addr_q + 1'b1;
        count_q <= count_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= M_Rdata_ram;
        wr_ptr           <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

`ifdef MEM_SEQ_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [TW-1:0] timer_q;
  logic          error_q;

  // The TIMEOUT-th unanswered strobe cycle abandons the burst.
  assign timeout_hit = strobe && !M_DataRdy && (timer_q == TW'(TIMEOUT - 1));
  assign error       = error_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (accept)           error_q <= 1'b0;
      else if (timeout_hit) error_q <= 1'b1;
      if ((state != REQ) || access_done || timeout_hit) timer_q <= '0;
      else if (strobe)                                  timer_q <= timer_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

endmodule
